// File: rtl/line_option_generator_if.sv
// rtl/line_option_generator_if.sv - option stream handshake between generator and option FIFO
interface line_option_generator_if #(
  parameter int SIZE = 3
);
  logic [SIZE-1:0] out_data;
  logic            out_is_index;
  logic            out_valid;
  logic            out_ready;

  modport master (
    output out_data,
    output out_is_index,
    output out_valid,
    input  out_ready
  );

  modport slave (
    input  out_data,
    input  out_is_index,
    input  out_valid,
    output out_ready
  );
endinterface

// File: rtl/line_option_generator.sv
// rtl/line_option_generator.sv - emits line token then every cell pattern matching the clue
module line_option_generator #(
  parameter int SIZE     = 3,
  parameter int MAX_RUNS = (SIZE + 1) / 2,
  parameter int RUN_W    = $clog2(SIZE + 1),
  parameter int NR_W     = $clog2(MAX_RUNS + 1)
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [SIZE-1:0]           line_idx,
  input  logic [NR_W-1:0]           num_runs,
  input  logic [MAX_RUNS*RUN_W-1:0] runs,
  line_option_generator_if.master   out_if,
  output logic                      busy,
  output logic                      done,
  output logic [6:0]                opt_count
);

  typedef enum logic [2:0] {
    IDLE,
    EMIT_IDX,
    SCAN,
    EMIT_OPT,
    FINISH
  } state_t;

  localparam logic [SIZE-1:0] ALL_ONES = '1;

  state_t                    state_q, state_d;
  logic [SIZE:0]             cand_q, cand_d;
  logic [NR_W-1:0]           nr_q, nr_d;
  logic [MAX_RUNS*RUN_W-1:0] runs_q, runs_d;
  logic [SIZE-1:0]           data_q, data_d;
  logic                      is_idx_q, is_idx_d;
  logic                      valid_q, valid_d;
  logic [6:0]                cnt_q, cnt_d;

  // Candidate matcher: walk the cells low to high, closing a run at each 0
  // (and at a virtual 0 past the top cell) and comparing its length with
  // the clue field of the same ordinal.
  int                        m_cnt;
  int                        m_len;
  logic                      m_ok;
  logic [RUN_W-1:0]          m_sel;
  logic                      match;

  // Combinational clue match for the current candidate
  always_comb begin
    m_cnt = 0;
    m_len = 0;
    m_ok  = 1'b1;
    m_sel = '0;
    for (int i = 0; i <= SIZE; i++) begin
      if ((i < SIZE) && cand_q[i]) begin
        m_len = m_len + 1;
      end else if (m_len != 0) begin
        m_sel = '0;
        for (int k = 0; k < MAX_RUNS; k++) begin
          if (k == m_cnt) m_sel = runs_q[k*RUN_W +: RUN_W];
        end
        if ((m_cnt < int'(nr_q)) && (m_cnt < MAX_RUNS)) begin
          if (m_len != int'(m_sel)) m_ok = 1'b0;
        end
        m_cnt = m_cnt + 1;
        m_len = 0;
      end
    end
    match = m_ok && (m_cnt == int'(nr_q));
  end

  // Next-state and next-register values for the whole line sequence
  always_comb begin
    state_d  = state_q;
    cand_d   = cand_q;
    nr_d     = nr_q;
    runs_d   = runs_q;
    data_d   = data_q;
    is_idx_d = is_idx_q;
    valid_d  = valid_q;
    cnt_d    = cnt_q;
    case (state_q)
      IDLE: begin
        if (start) begin
          nr_d     = num_runs;
          runs_d   = runs;
          cand_d   = '0;
          cnt_d    = '0;
          data_d   = line_idx;
          is_idx_d = 1'b1;
          valid_d  = 1'b1;
          state_d  = EMIT_IDX;
        end
      end
      EMIT_IDX: begin
        if (valid_q && out_if.out_ready) begin
          valid_d  = 1'b0;
          is_idx_d = 1'b0;
          state_d  = SCAN;
        end
      end
      SCAN: begin
        if (match) begin
          data_d   = cand_q[SIZE-1:0];
          is_idx_d = 1'b0;
          valid_d  = 1'b1;
          state_d  = EMIT_OPT;
        end else if (cand_q[SIZE-1:0] == ALL_ONES) begin
          state_d = FINISH;
        end else begin
          cand_d = cand_q + 1'b1;
        end
      end
      EMIT_OPT: begin
        if (valid_q && out_if.out_ready) begin
          valid_d = 1'b0;
          if (cnt_q != 7'h7f) cnt_d = cnt_q + 7'd1;
          cand_d  = cand_q + 1'b1;
          state_d = (cand_q[SIZE-1:0] == ALL_ONES) ? FINISH : SCAN;
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      cand_q   <= '0;
      nr_q     <= '0;
      runs_q   <= '0;
      data_q   <= '0;
      is_idx_q <= 1'b0;
      valid_q  <= 1'b0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      cand_q   <= cand_d;
      nr_q     <= nr_d;
      runs_q   <= runs_d;
      data_q   <= data_d;
      is_idx_q <= is_idx_d;
      valid_q  <= valid_d;
      cnt_q    <= cnt_d;
    end
  end

  assign out_if.out_data     = data_q;
  assign out_if.out_is_index = is_idx_q;
  assign out_if.out_valid    = valid_q;
  assign busy                = (state_q != IDLE);
  assign done                = (state_q == FINISH);
  assign opt_count           = cnt_q;

endmodule

// File: tb/tb_line_option_generator.sv
// tb/tb_line_option_generator.sv - scoreboard bench with randomized clues and ready patterns
module tb_line_option_generator;
  localparam int SIZE     = 3;
  localparam int MAX_RUNS = (SIZE + 1) / 2;
  localparam int RUN_W    = $clog2(SIZE + 1);
  localparam int NR_W     = $clog2(MAX_RUNS + 1);

  typedef int runs_t[MAX_RUNS];
  typedef struct {
    logic [SIZE-1:0] data;
    logic            is_idx;
  } exp_t;

  logic                      clk = 1'b0;
  logic                      rst;
  logic                      start;
  logic [SIZE-1:0]           line_idx;
  logic [NR_W-1:0]           num_runs;
  logic [MAX_RUNS*RUN_W-1:0] runs;
  logic                      busy;
  logic                      done;
  logic [6:0]                opt_count;

  line_option_generator_if #(.SIZE(SIZE)) oif ();

  line_option_generator #(.SIZE(SIZE)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .line_idx  (line_idx),
    .num_runs  (num_runs),
    .runs      (runs),
    .out_if    (oif),
    .busy      (busy),
    .done      (done),
    .opt_count (opt_count)
  );

  always #5 clk = ~clk;

  exp_t exp_q[$];
  int   tests = 0;
  int   fails = 0;
  int   ready_mode = 0;
  int   stall_cnt = 0;

  task automatic chk(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d want %0d", name, got, want);
    end
  endtask

  // Reference: decompose the pattern into its list of run lengths and compare with the clue
  function automatic bit model_match(input int p, input int nr, input runs_t r);
    int lens[$];
    int len = 0;
    for (int i = 0; i < SIZE; i++) begin
      if (((p >> i) & 1) == 1) len++;
      else begin
        if (len > 0) lens.push_back(len);
        len = 0;
      end
    end
    if (len > 0) lens.push_back(len);
    if (lens.size() != nr) return 1'b0;
    for (int k = 0; k < nr; k++) if (lens[k] != r[k]) return 1'b0;
    return 1'b1;
  endfunction

  // Ready driver: 0 always, 1 random, 2 five-cycle stall per transfer, 3 never
  initial begin
    oif.out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      case (ready_mode)
        0: oif.out_ready = 1'b1;
        1: oif.out_ready = 1'($urandom_range(0, 1));
        2: begin
          if (oif.out_valid) begin
            if (stall_cnt < 5) begin
              oif.out_ready = 1'b0;
              stall_cnt++;
            end else begin
              oif.out_ready = 1'b1;
              stall_cnt = 0;
            end
          end else begin
            oif.out_ready = 1'b0;
          end
        end
        default: oif.out_ready = 1'b0;
      endcase
    end
  end

  // Monitor: pop expected item on every handshake, check hold during stalls
  initial begin
    logic            prev_stall;
    logic [SIZE-1:0] prev_data;
    logic            prev_idx;
    exp_t            e;
    prev_stall = 1'b0;
    prev_data  = '0;
    prev_idx   = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) begin
          tests++;
          if (!(oif.out_valid && oif.out_data == prev_data && oif.out_is_index == prev_idx)) begin
            fails++;
            $display("FAIL stall_hold: got valid=%0b data=%0d idx=%0b want valid=1 data=%0d idx=%0b",
                     oif.out_valid, oif.out_data, oif.out_is_index, prev_data, prev_idx);
          end
        end
        if (oif.out_valid && oif.out_ready) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL stream_extra: got data=%0d idx=%0b want nothing", oif.out_data, oif.out_is_index);
          end else begin
            e = exp_q.pop_front();
            if (oif.out_data != e.data || oif.out_is_index != e.is_idx) begin
              fails++;
              $display("FAIL stream_item: got data=%0d idx=%0b want data=%0d idx=%0b",
                       oif.out_data, oif.out_is_index, e.data, e.is_idx);
            end
          end
        end
        prev_stall = oif.out_valid && !oif.out_ready;
        prev_data  = oif.out_data;
        prev_idx   = oif.out_is_index;
      end
    end
  end

  // Push the expected stream for one line and return the expected count
  task automatic expect_line(input int idx, input int nr, input runs_t r, output int cnt);
    exp_t e;
    cnt = 0;
    e.data = 3'(idx);
    e.is_idx = 1'b1;
    exp_q.push_back(e);
    for (int p = 0; p < (1 << SIZE); p++) begin
      if (model_match(p, nr, r)) begin
        e.data = 3'(p);
        e.is_idx = 1'b0;
        exp_q.push_back(e);
        cnt++;
      end
    end
  endtask

  task automatic drive_start(input int idx, input int nr, input runs_t r);
    logic [MAX_RUNS*RUN_W-1:0] rv;
    rv = '0;
    for (int k = 0; k < MAX_RUNS; k++) rv[k*RUN_W +: RUN_W] = r[k][RUN_W-1:0];
    line_idx = idx[SIZE-1:0];
    num_runs = nr[NR_W-1:0];
    runs     = rv;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    line_idx = SIZE'($urandom);
    num_runs = NR_W'($urandom);
    runs     = (MAX_RUNS*RUN_W)'($urandom);
  endtask

  task automatic run_line(input int idx, input int nr, input runs_t r, input int mode, input bit poke);
    int cnt;
    int cyc;
    ready_mode = mode;
    stall_cnt = 0;
    expect_line(idx, nr, r, cnt);
    @(posedge clk);
    #1;
    drive_start(idx, nr, r);
    chk("busy_after_start", int'(busy), 1);
    if (poke) begin
      line_idx = SIZE'(~idx);
      num_runs = '0;
      runs     = '1;
      start    = 1'b1;
      @(posedge clk);
      #1;
      start    = 1'b0;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      cyc++;
    end while (!done && cyc < 2000);
    if (!done) begin
      chk("done_timeout", cyc, -1);
    end else begin
      chk("opt_count", int'(opt_count), (cnt > 127) ? 127 : cnt);
      chk("stream_left", exp_q.size(), 0);
      @(negedge clk);
      chk("done_pulse_width", int'(done), 0);
      chk("busy_after_done", int'(busy), 0);
    end
    exp_q.delete();
  endtask

  initial begin
    runs_t r;
    int    cnt;
    int    cyc;
    rst      = 1'b1;
    start    = 1'b0;
    line_idx = '0;
    num_runs = '0;
    runs     = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", int'(oif.out_valid), 0);
    chk("rst_is_index", int'(oif.out_is_index), 0);
    chk("rst_data", int'(oif.out_data), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_opt_count", int'(opt_count), 0);
    rst = 1'b0;

    r = '{1, 1}; run_line(2, 2, r, 0, 1'b0);
    chk("two_singles_count", int'(opt_count), 1);
    r = '{1, 0}; run_line(4, 1, r, 0, 1'b0);
    chk("single_one_count", int'(opt_count), 3);
    r = '{0, 0}; run_line(1, 0, r, 0, 1'b0);
    chk("empty_clue_count", int'(opt_count), 1);
    r = '{3, 0}; run_line(0, 1, r, 0, 1'b0);
    chk("full_run_count", int'(opt_count), 1);
    r = '{1, 0}; run_line(4, 1, r, 2, 1'b0);
    chk("stalled_count", int'(opt_count), 3);
    r = '{0, 0}; run_line(5, 1, r, 0, 1'b0);
    chk("zero_run_count", int'(opt_count), 0);
    r = '{2, 0}; run_line(3, 1, r, 1, 1'b1);
    chk("poke_busy_count", int'(opt_count), 2);
    r = '{2, 2}; run_line(1, 2, r, 0, 1'b0);

    // Reset while the second option of runs={1} is being offered
    ready_mode = 2;
    stall_cnt = 0;
    r = '{1, 0};
    expect_line(4, 1, r, cnt);
    @(posedge clk);
    #1;
    drive_start(4, 1, r);
    cyc = 0;
    while (!(oif.out_valid && !oif.out_is_index && oif.out_data == 3'b010) && cyc < 500) begin
      @(posedge clk);
      #1;
      cyc++;
    end
    chk("reach_emit_opt", int'(cyc < 500), 1);
    chk("count_before_rst", int'(opt_count), 1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_valid", int'(oif.out_valid), 0);
    chk("midrst_busy", int'(busy), 0);
    chk("midrst_opt_count", int'(opt_count), 0);
    rst = 1'b0;
    exp_q.delete();
    r = '{1, 1}; run_line(2, 2, r, 0, 1'b0);
    chk("after_rst_count", int'(opt_count), 1);

    for (int t = 0; t < 25; t++) begin
      r[0] = $urandom_range(0, 3);
      r[1] = $urandom_range(0, 3);
      run_line($urandom_range(0, 2*SIZE-1), $urandom_range(0, MAX_RUNS), r,
               $urandom_range(0, 2), 1'($urandom_range(0, 1)));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/line_option_generator.md
Name: line_option_generator

Overview:
Producer end of the solver's option stream. For one line (row or column) and its clue run-lengths, it emits a line-index token, then every SIZE-bit cell pattern that satisfies the clue, over a valid/ready handshake. It also reports the option count, which initialises the per-line options-amount table.
It sits between the clue parser and the option FIFO, and is invoked once per line (2*SIZE times) before the solver is started.

Parameters:
SIZE, 3, line length in cells; also the token/option width
MAX_RUNS, (SIZE+1)/2, max clue runs per line
RUN_W, $clog2(SIZE+1), width of one run-length field
NR_W, $clog2(MAX_RUNS+1), width of num_runs

Ports:
clk  in  1  clock
rst  in  1  reset, synchronous, active-high
start  in  1  one-cycle request to generate options for one line; honoured only in IDLE
line_idx  in  SIZE  line index (0..SIZE-1 rows, SIZE..2*SIZE-1 columns); sampled on start
num_runs  in  NR_W  number of clue runs; sampled on start
runs  in  MAX_RUNS*RUN_W  run lengths; run k at [k*RUN_W +: RUN_W]; run 0 is leftmost (lowest cell index); sampled on start
out_data  out  SIZE  token or option; bit i = cell i, 1 = filled
out_is_index  out  1  1 when out_data is the line-index token
out_valid  out  1  out_data valid
out_ready  in  1  downstream (FIFO) accepts when out_valid && out_ready
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse when the line is complete
opt_count  out  7  matching options emitted for the last line; held until the next start

Behaviour:
- Reset: state IDLE; out_valid=0, out_is_index=0, out_data=0, done=0, busy=0, opt_count=0; candidate counter=0.
- Reset mid-operation aborts immediately; the line is not resumed.
- States: IDLE, EMIT_IDX, SCAN, EMIT_OPT, FINISH.
- IDLE:
  - start latches line_idx, num_runs and runs; clears opt_count and candidate cand (SIZE+1 bits, no wrap).
  - Next state EMIT_IDX.
  - start outside IDLE is ignored.
- EMIT_IDX: out_valid=1, out_is_index=1, out_data=latched line_idx. On handshake go to SCAN with out_valid=0.
- SCAN: one candidate per cycle, matched combinationally.
  - Match when cand[SIZE-1:0] has exactly num_runs maximal runs of 1s and run k length == runs[k] for all k<num_runs.
  - Fields k>=num_runs are ignored.
  - On match: register out_data=cand, out_is_index=0, out_valid=1; go to EMIT_OPT.
  - No match, cand < 2^SIZE-1: cand+1, stay in SCAN.
  - No match, cand == 2^SIZE-1: go to FINISH.
- EMIT_OPT:
  - Hold out_data/out_valid stable while out_ready=0.
  - On handshake: out_valid=0, opt_count+1 (saturating at 127), cand+1.
  - Then go to SCAN, or to FINISH if the accepted option was cand=2^SIZE-1.
- FINISH: done=1 for exactly one cycle; go to IDLE. opt_count is final and valid in the done cycle.
- Stream order: exactly one token per line, always first; then options in ascending numeric order.
- Throughput: one option per cycle at most; a matched candidate appears on out_valid the cycle after its SCAN cycle.
- Latency: start to done is at most 2 + 2^SIZE + 2*matches cycles when out_ready=1.
- num_runs=0: only pattern 0 matches; opt_count=1.
- Any run==0 within num_runs, or runs not fitting in SIZE: zero matches; token still emitted; opt_count=0.
- A handshake occurs only when out_valid && out_ready; out_ready while out_valid=0 has no effect.

Test Plan:
- SIZE=3, line_idx=2, num_runs=2, runs={1,1}, out_ready=1 -> stream: token 3'b010 (is_index=1), then 3'b101; done pulse; opt_count=1.
- line_idx=4, num_runs=1, runs={1} -> token 3'b100, then 3'b001, 3'b010, 3'b100 in order; opt_count=3.
- num_runs=0 -> token, then single option 3'b000; opt_count=1. runs={3} -> single option 3'b111; opt_count=1.
- runs={1}, out_ready low 5 cycles at each transfer -> out_data/out_valid stable while stalled; no loss or duplicate; opt_count=3.
- Invalid clue runs={0} with num_runs=1 -> token only; opt_count=0; done pulse. start asserted while busy -> ignored, latched clue unchanged.
- rst asserted during EMIT_OPT -> next cycle out_valid=0, busy=0, opt_count=0; a fresh start runs a full, correct sequence.
